twd_seq_ctrl: RTL

Frame sequencer for the 16-lane radix-2 twiddle-multiply stage of the FFT pipeline. It sits between the butterfly stage's valid stream and the twiddle multiplier. It counts beats within a frame and derives the twiddle index and multiplier mode for each beat. It gates the multiplier enable and produces output framing (valid/sof/eof) aligned to the multiplier's one-cycle registered output.

---
 rtl/twd_pkg.sv | 46 ++++
 rtl/twd_seq_ctrl_if.sv | 41 ++++
 rtl/twd_beat_cnt.sv | 63 ++++++
 rtl/twd_seq_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/twd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : twd_pkg
//  Purpose  : Shared types and helpers for the twiddle-multiply sequencer and
//             the twiddle multiplier itself.
//             - twd_mode_t   : 2-bit multiplier mode (UNITY/NEG_J/W8_1/W8_3)
//             - seq_state_t  : sequencer frame state
//             - twd_mode_of  : twiddle index -> multiplier mode map
//             - default NUM_BEATS / NUM_IDX values
//  Revision : 1.0  initial release
// ============================================================================
package twd_pkg;

  localparam int TWD_NUM_BEATS_DEF = 16;
  localparam int TWD_NUM_IDX_DEF   = 8;

  // Argument width of twd_mode_of; wide enough for any supported NUM_IDX.
  localparam int TWD_IDX_FN_W      = 8;

  typedef enum logic [1:0] {
    UNITY = 2'd0,   // multiply by 1
    NEG_J = 2'd1,   // multiply by -j
    W8_1  = 2'd2,   // multiply by (181 - j181)/256
    W8_3  = 2'd3    // multiply by (-181 - j181)/256
  } twd_mode_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Twiddle index to multiplier mode. Only odd indices above 1 need a
  // non-trivial rotation in this radix-2 stage; everything else is unity.
  function automatic twd_mode_t twd_mode_of(input logic [TWD_IDX_FN_W-1:0] idx);
    twd_mode_t m;
    case (idx)
      8'd3:    m = NEG_J;
      8'd5:    m = W8_1;
      8'd7:    m = W8_3;
      default: m = UNITY;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/twd_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : twd_seq_ctrl_if
//  Purpose  : Beat stream from the butterfly stage into the sequencer and the
//             control/framing stream out to the twiddle multiplier.
//  Signals  : i_valid, i_sof, i_bypass          - upstream beat + frame info
//             o_twd_en, o_twd_idx, o_twd_mode   - multiplier control (comb)
//             o_valid, o_sof, o_eof, o_err      - output framing (registered)
//  Modports : master - drives the beat stream, observes the outputs
//             slave  - the sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface twd_seq_ctrl_if
  import twd_pkg::*;
#(
  parameter int IW = 3
);

  logic          i_valid;
  logic          i_sof;
  logic          i_bypass;
  logic          o_twd_en;
  logic [IW-1:0] o_twd_idx;
  twd_mode_t     o_twd_mode;
  logic          o_valid;
  logic          o_sof;
  logic          o_eof;
  logic          o_err;

  modport master (
    output i_valid, i_sof, i_bypass,
    input  o_twd_en, o_twd_idx, o_twd_mode, o_valid, o_sof, o_eof, o_err
  );

  modport slave (
    input  i_valid, i_sof, i_bypass,
    output o_twd_en, o_twd_idx, o_twd_mode, o_valid, o_sof, o_eof, o_err
  );

endinterface
`default_nettype wire

// File: rtl/twd_beat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : twd_beat_cnt
//  Purpose  : Beat-within-frame counter with enable, restart and wrap.
//             The effective beat is 0 on a restart beat, else the count.
//             On an enabled beat the counter advances from the effective
//             beat and wraps to 0 after the last beat of the frame.
//  Ports    : clk, rstn   - clock, asynchronous active-low reset
//             i_en        - advance on this beat
//             i_restart   - this beat is beat 0 of a (new) frame
//             o_idx       - twiddle index of the effective beat
//             o_last      - effective beat is the last of the frame
//  Revision : 1.0  initial release
// ============================================================================
module twd_beat_cnt #(
  parameter int NUM_BEATS = 16,
  parameter int NUM_IDX   = 8,
  parameter int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
  parameter int IW        = (NUM_IDX   > 1) ? $clog2(NUM_IDX)   : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_en,
  input  logic          i_restart,
  output logic [IW-1:0] o_idx,
  output logic          o_last
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

  logic [BW-1:0] cnt_q;
  logic [BW-1:0] cnt_d;
  logic [BW-1:0] eff;

  always_comb begin
    eff    = i_restart ? '0 : cnt_q;
    o_last = (eff == LAST_BEAT);
    cnt_d  = cnt_q;
    if (i_en) begin
      cnt_d = o_last ? '0 : (eff + BW'(1));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Beats per index is a power of two, so the index is simply the upper
  // IW bits of the effective beat number.
  generate
    if (NUM_IDX == 1) begin : g_idx_single
      assign o_idx = '0;
    end else begin : g_idx_msbs
      assign o_idx = eff[BW-1 -: IW];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/twd_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : twd_seq_ctrl
//  Purpose  : Frame sequencer for the 16-lane radix-2 twiddle-multiply stage.
//             Counts beats within a frame, derives twiddle index and mode
//             per beat, gates the multiplier enable and produces output
//             framing aligned to the multiplier's one-cycle register.
//  Ports    : clk, rstn          - clock, asynchronous active-low reset
//             bus (slave)        - beat stream in, multiplier control and
//                                  framing out (see twd_seq_ctrl_if)
//             o_frame_cnt[15:0]  - completed frames, wrapping   (stats only)
//             o_err_cnt[7:0]     - framing errors, saturating   (stats only)
//  Options  : TWD_SEQ_STATS_EN   - adds the two statistics counters/ports
//  Revision : 1.0  initial release
// ============================================================================
module twd_seq_ctrl
  import twd_pkg::*;
#(
  parameter int NUM_BEATS = TWD_NUM_BEATS_DEF,
  parameter int NUM_IDX   = TWD_NUM_IDX_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  twd_seq_ctrl_if.slave bus
`ifdef TWD_SEQ_STATS_EN
  ,
  output logic [15:0]  o_frame_cnt,
  output logic [7:0]   o_err_cnt
`endif
);

  localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int IW = (NUM_IDX   > 1) ? $clog2(NUM_IDX)   : 1;

  seq_state_t    state_q, state_d;
  logic          bypass_q, bypass_d;
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic          eof_q, eof_d;
  logic          err_q, err_d;

  logic          w_accept;
  logic          w_stray;
  logic          w_abort;
  logic          w_last;
  logic          w_cnt_last;
  logic          w_byp_eff;
  logic [IW-1:0] w_idx;
  twd_mode_t     w_mode;

  twd_beat_cnt #(
    .NUM_BEATS (NUM_BEATS),
    .NUM_IDX   (NUM_IDX),
    .BW        (BW),
    .IW        (IW)
  ) u_beat_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .i_en      (w_accept),
    .i_restart (bus.i_sof),
    .o_idx     (w_idx),
    .o_last    (w_cnt_last)
  );

  always_comb begin
    // A sof beat is always taken; a non-sof beat only inside a frame.
    w_accept  = bus.i_valid & ((state_q == ST_RUN) | bus.i_sof);
    w_stray   = bus.i_valid & ~bus.i_sof & (state_q == ST_IDLE);
    w_abort   = bus.i_valid &  bus.i_sof & (state_q == ST_RUN);
    w_last    = w_accept & w_cnt_last;

    // The sof beat already uses the bypass it brings with it.
    w_byp_eff = bus.i_sof ? bus.i_bypass : bypass_q;

    w_mode = UNITY;
    if (w_accept && !w_byp_eff) begin
      w_mode = twd_mode_of(TWD_IDX_FN_W'(w_idx));
    end

    state_d  = state_q;
    bypass_d = bypass_q;
    if (w_accept) begin
      // Returning to IDLE on the last beat lets a sof on the next cycle
      // start the following frame without a bubble.
      state_d = w_last ? ST_IDLE : ST_RUN;
      if (bus.i_sof) begin
        bypass_d = bus.i_bypass;
      end
    end

    valid_d = w_accept;
    sof_d   = w_accept & bus.i_sof;
    eof_d   = w_last;
    err_d   = w_stray | w_abort;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      bypass_q <= 1'b0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bypass_q <= bypass_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_twd_en   = w_accept;
  assign bus.o_twd_idx  = w_accept ? w_idx : '0;
  assign bus.o_twd_mode = w_mode;
  assign bus.o_valid    = valid_q;
  assign bus.o_sof      = sof_q;
  assign bus.o_eof      = eof_q;
  assign bus.o_err      = err_q;

`ifdef TWD_SEQ_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // Counters step on the same edge that raises o_eof / o_err.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (eof_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`endif

endmodule
`default_nettype wire
